// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, pattern-select encoding and colour helpers.
// Used by vga_timing_gen and, when VGA_TEST_PATTERN_EN is defined, vga_pattern_gen.
package vga_timing_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_WHITE = 2'd2,
    PAT_RAMP  = 2'd3
  } pat_sel_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_WHITE   = 12'hFFF;
  localparam rgb_t RGB_YELLOW  = 12'hFF0;
  localparam rgb_t RGB_CYAN    = 12'h0FF;
  localparam rgb_t RGB_GREEN   = 12'h0F0;
  localparam rgb_t RGB_MAGENTA = 12'hF0F;
  localparam rgb_t RGB_RED     = 12'hF00;
  localparam rgb_t RGB_BLUE    = 12'h00F;
  localparam rgb_t RGB_BLACK   = 12'h000;

  // Colour-bar order, left to right
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern colour from active-area x/y and pattern select.
// Output is black outside the active area; the parent registers it.
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 10
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         sel,
  input  logic               de,
  output rgb_t               rgb
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  int  bar_idx;
  logic grid;

  always_comb begin
    rgb     = RGB_BLACK;
    bar_idx = int'(x) / BAR_W;
    if (bar_idx > 7) bar_idx = 7;
    grid = (int'(x) % 32 == 0) || (int'(y) % 32 == 0) ||
           (int'(x) == H_ACTIVE - 1) || (int'(y) == V_ACTIVE - 1);
    case (pat_sel_e'(sel))
      PAT_BARS:  rgb = bar_colour(3'(bar_idx));
      PAT_GRID:  rgb = grid ? RGB_WHITE : RGB_BLACK;
      PAT_WHITE: rgb = RGB_WHITE;
      PAT_RAMP:  rgb.r = x[COORD_W-1 -: 4];
      default:   rgb = RGB_BLACK;
    endcase
    if (!de) rgb = RGB_BLACK;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, DE, x/y, line/frame markers.
// Define VGA_TEST_PATTERN_EN to drive red/green/blue from vga_pattern_gen.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int COORD_W   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pixelEnable,
  input  logic [1:0]         patternSel,
  output logic               hsync,
  output logic               vsync,
  output logic               canDisplayImage,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               lineStart,
  output logic               frameStart,
  output logic [15:0]        frameCount,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               h_act, v_act, de_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               first_q;
  rgb_t               rgb_nxt, rgb_q;

  always_comb begin
    h_act  = (int'(h_cnt) >= H_START) && (int'(h_cnt) < H_START + H_ACTIVE);
    v_act  = (int'(v_cnt) >= V_START) && (int'(v_cnt) < V_START + V_ACTIVE);
    de_nxt = h_act && v_act;
    x_nxt  = de_nxt ? COORD_W'(int'(h_cnt) - H_START) : '0;
    y_nxt  = de_nxt ? COORD_W'(int'(v_cnt) - V_START) : '0;
    hs_nxt = (int'(h_cnt) < H_SYNC) ? HS_ON : ~HS_ON;
    vs_nxt = (int'(v_cnt) < V_SYNC) ? VS_ON : ~VS_ON;
    ls_nxt = (h_cnt == '0);
    fs_nxt = ls_nxt && (v_cnt == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [1:0] sel_q, sel_cur;

  // The frame's select is captured at its first pixel, so count (0,0) sees it live
  assign sel_cur = fs_nxt ? patternSel : sel_q;

  always_ff @(posedge clock) begin
    if (reset)                      sel_q <= '0;
    else if (pixelEnable && fs_nxt) sel_q <= patternSel;
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COORD_W  (COORD_W)
  ) u_pat (
    .x   (x_nxt),
    .y   (y_nxt),
    .sel (sel_cur),
    .de  (de_nxt),
    .rgb (rgb_nxt)
  );
`else
  wire unused_pattern_sel = &{1'b0, patternSel};
  assign rgb_nxt = RGB_BLACK;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      hsync           <= ~HS_ON;
      vsync           <= ~VS_ON;
      canDisplayImage <= 1'b0;
      x               <= '0;
      y               <= '0;
      lineStart       <= 1'b0;
      frameStart      <= 1'b0;
      frameCount      <= '0;
      first_q         <= 1'b1;
      rgb_q           <= RGB_BLACK;
    end else if (pixelEnable) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      hsync           <= hs_nxt;
      vsync           <= vs_nxt;
      canDisplayImage <= de_nxt;
      x               <= x_nxt;
      y               <= y_nxt;
      lineStart       <= ls_nxt;
      frameStart      <= fs_nxt;
      rgb_q           <= rgb_nxt;
      // The frame that starts right after reset is not a completed frame
      if (fs_nxt) begin
        if (first_q) first_q    <= 1'b0;
        else         frameCount <= frameCount + 1'b1;
      end
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small raster (25x11 counts) so whole frames are cheap.
// Colour expectations follow VGA_TEST_PATTERN_EN when it is defined for the build.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int CW = 5;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int FRAME = HT * VT;          // 275

  logic          clock = 1'b0;
  logic          reset, pixelEnable;
  logic [1:0]    patternSel;
  logic          hsync, vsync, canDisplayImage, lineStart, frameStart;
  logic [CW-1:0] x, y;
  logic [15:0]   frameCount;
  logic [3:0]    red, green, blue;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(0), .VSYNC_POL(1), .COORD_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .pixelEnable(pixelEnable), .patternSel(patternSel),
    .hsync(hsync), .vsync(vsync), .canDisplayImage(canDisplayImage),
    .x(x), .y(y), .lineStart(lineStart), .frameStart(frameStart),
    .frameCount(frameCount), .red(red), .green(green), .blue(blue)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] rgb();
    return {20'd0, red, green, blue};
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hsync"}, hsync, 1'b1);
    chk({tag, "_vsync"}, vsync, 1'b0);
    chk({tag, "_de"}, canDisplayImage, 1'b0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_ls"}, lineStart, 1'b0);
    chk({tag, "_fs"}, frameStart, 1'b0);
    chk({tag, "_fc"}, frameCount, 0);
    chk({tag, "_rgb"}, rgb(), 0);
  endtask

  initial begin
    int hs_cnt, vs_cnt, de_cnt, ls_cnt, fs_cnt, idle_bad, hold_bad;
    int first_de, last_de;
    logic [CW-1:0] fx, fy, lx, ly;
    logic p_hs, p_vs, p_de;
    logic [CW-1:0] p_x, p_y;
    logic [15:0] p_fc;
    logic [31:0] bar_x0, bar_x2, bar_x15, white_x2;

`ifdef VGA_TEST_PATTERN_EN
    bar_x0 = 32'hFFF; bar_x2 = 32'hFF0; bar_x15 = 32'h000; white_x2 = 32'hFFF;
`else
    bar_x0 = 32'h0;   bar_x2 = 32'h0;   bar_x15 = 32'h0;   white_x2 = 32'h0;
`endif

    reset = 1'b1; pixelEnable = 1'b1; patternSel = 2'd0;
    run(2);
    chk_reset_state("rst");

    // First enabled edge after release shows count (0,0)
    reset = 1'b0;
    tick();
    chk("rel_fs", frameStart, 1'b1);
    chk("rel_ls", lineStart, 1'b1);
    chk("rel_hsync", hsync, 1'b0);
    chk("rel_vsync", vsync, 1'b1);
    chk("rel_fc", frameCount, 0);

    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; idle_bad = 0;
    first_de = -1; last_de = -1; fx = '0; fy = '0; lx = '0; ly = '0;
    for (int n = 0; n < FRAME; n++) begin
      if (!hsync) hs_cnt++;
      if (vsync) vs_cnt++;
      if (lineStart) ls_cnt++;
      if (frameStart) fs_cnt++;
      if (canDisplayImage) begin
        de_cnt++;
        if (first_de < 0) begin first_de = n; fx = x; fy = y; end
        last_de = n; lx = x; ly = y;
      end else if (x != 0 || y != 0) begin
        idle_bad++;
      end
      tick();
    end
    chk("f1_hsync_low", hs_cnt, 33);
    chk("f1_vsync_high", vs_cnt, 50);
    chk("f1_de_cycles", de_cnt, 96);
    chk("f1_lines", ls_cnt, 11);
    chk("f1_frames", fs_cnt, 1);
    chk("f1_first_de_at", first_de, 107);
    chk("f1_first_x", fx, 0);
    chk("f1_first_y", fy, 0);
    chk("f1_last_de_at", last_de, 247);
    chk("f1_last_x", lx, 15);
    chk("f1_last_y", ly, 5);
    chk("f1_xy_idle_zero", idle_bad, 0);
    chk("f2_fs", frameStart, 1'b1);
    chk("f2_fc", frameCount, 1);

    // Half-rate enable: every enabled count is held for one extra cycle
    hs_cnt = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; hold_bad = 0;
    for (int m = 0; m < 2 * FRAME; m++) begin
      pixelEnable = (m % 2 == 1);
      p_hs = hsync; p_vs = vsync; p_de = canDisplayImage; p_x = x; p_y = y; p_fc = frameCount;
      tick();
      if (!pixelEnable) begin
        if (hsync !== p_hs || vsync !== p_vs || canDisplayImage !== p_de ||
            x !== p_x || y !== p_y || frameCount !== p_fc ||
            lineStart !== 1'b0 || frameStart !== 1'b0) hold_bad++;
      end
      if (!hsync) hs_cnt++;
      if (canDisplayImage) de_cnt++;
      if (lineStart) ls_cnt++;
      if (frameStart) fs_cnt++;
    end
    pixelEnable = 1'b1;
    chk("half_hold", hold_bad, 0);
    chk("half_hsync_low", hs_cnt, 66);
    chk("half_de_cycles", de_cnt, 192);
    chk("half_lines", ls_cnt, 11);
    chk("half_frames", fs_cnt, 1);
    chk("half_end_fs", frameStart, 1'b1);
    chk("half_end_fc", frameCount, 2);

    // Mid-frame reset at count (10,5)
    run(5 * HT + 10);
    chk("mid_de", canDisplayImage, 1'b1);
    chk("mid_x", x, 3);
    chk("mid_y", y, 1);
    reset = 1'b1;
    tick();
    chk_reset_state("midrst");
    reset = 1'b0;
    tick();
    chk("mid_rel_fs", frameStart, 1'b1);
    chk("mid_rel_fc", frameCount, 0);
    chk("mid_rel_hsync", hsync, 1'b0);
    chk("mid_rel_vsync", vsync, 1'b1);

    // Colour bars, then a mid-frame select change that waits for the next frame
    run(4 * HT + 7);
    chk("pat_x0", rgb(), bar_x0);
    chk("pat_x0_de", canDisplayImage, 1'b1);
    run(2);
    chk("pat_x2", rgb(), bar_x2);
    run(13);
    chk("pat_x15", rgb(), bar_x15);
    chk("pat_x15_pos", x, 15);
    patternSel = 2'd2;
    run(12);
    chk("pat_mid_change_x2", rgb(), bar_x2);
    run(FRAME - (5 * HT + 9));
    chk("pat_next_fs", frameStart, 1'b1);
    chk("pat_next_fc", frameCount, 1);
    chk("pat_blank_rgb", rgb(), 0);
    run(4 * HT + 9);
    chk("pat_white_x2_pos", x, 2);
    chk("pat_white_x2", rgb(), white_x2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator; replaces the fixed 640x480 sync/counter block. Produces sync, display-enable, active-area pixel coordinates and frame/line markers for any timing set, with a pixel clock-enable and configurable sync polarity. Sits between the pixel clock domain and the monitor-tester pattern/output logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 1, level of hsync during sync pulse (1 = high)
VSYNC_POL, 1, level of vsync during sync pulse
COORD_W, 10, width of x/y; must hold H_ACTIVE-1 and V_ACTIVE-1

Ports:
clock  in  1  pixel clock; single clock domain
reset  in  1  synchronous, active-high reset
pixelEnable  in  1  counters advance only when high
patternSel  in  2  test pattern select (optional feature)
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
canDisplayImage  out  1  high in active area
x  out  COORD_W  active-area column, 0 outside active
y  out  COORD_W  active-area row, 0 outside active
lineStart  out  1  one enabled-cycle pulse at hCount==0
frameStart  out  1  one enabled-cycle pulse at hCount==0, vCount==0
frameCount  out  16  frames completed, wraps 0xFFFF->0
red/green/blue  out  4 each  pattern colour

Behaviour:
- Single clock; reset synchronous, active-high, the only reset.
- H_TOTAL = sum of H params; V_TOTAL likewise. Internal hCount 0..H_TOTAL-1, vCount 0..V_TOTAL-1; widths $clog2(TOTAL).
- Line order from count 0: sync, back porch, active, front porch. H_START = H_SYNC+H_BACK; V_START = V_SYNC+V_BACK.
- On enabled cycle: hCount wraps at H_TOTAL-1 to 0; vCount increments only when hCount==H_TOTAL-1, wraps at V_TOTAL-1 to 0 (exactly V_TOTAL lines).
- pixelEnable low: counters and all outputs hold; lineStart/frameStart forced 0.
- All outputs registered, latency 1 enabled cycle from counter state; all outputs mutually aligned.
- hsync = HSYNC_POL while hCount < H_SYNC, else inverse; vsync likewise with vCount < V_SYNC.
- canDisplayImage = hCount in [H_START, H_START+H_ACTIVE) and vCount in [V_START, V_START+V_ACTIVE).
- x = hCount-H_START, y = vCount-V_START when active; both 0 otherwise.
- frameCount increments on output cycle where frameStart asserts, except the first after reset.
- Reset: counters 0; hsync=~HSYNC_POL, vsync=~VSYNC_POL, canDisplayImage/lineStart/frameStart 0, x/y/frameCount/colours 0. Reset mid-line aborts immediately; first enabled cycle after release outputs counter state 0 (frameStart=1, sync asserted).

Optional Feature:
Macro VGA_TEST_PATTERN_EN.
With: red/green/blue from built-in generator, same stage/latency as canDisplayImage; forced 0 outside active. patternSel sampled only at frameStart (mid-frame change applies next frame). 0 = 8 vertical bars of width H_ACTIVE/8: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000. 1 = white grid lines at x%32==0 or y%32==0, plus border at x/y edges, black elsewhere. 2 = solid white. 3 = red gradient red = x[COORD_W-1 -: 4], green/blue 0.
Without: colour ports present, tied 0; patternSel ignored.

Decomposition:
- Package vga_timing_pkg: 640x480@60 and 800x600@60 timing constants, pattern-select enum, colour constants.
- Sub-module vga_pattern_gen (combinational pattern from x/y/select, registered by parent), instantiated only under VGA_TEST_PATTERN_EN.

Test Plan:
- Defaults, pixelEnable=1, run 2 frames -> hsync high 96 of every 800 cycles; vsync high 1600 of 420000; frameStart period 420000; lineStart period 800.
- Defaults -> first canDisplayImage at hCount=144, vCount=35 with x=0,y=0; last at x=639,y=479; exactly 307200 DE cycles per frame.
- pixelEnable toggling every cycle -> all periods double; outputs hold while low; frameStart high 1 cycle per frame.
- reset asserted 1 cycle at hCount=400, vCount=100 -> next cycle all outputs at reset values; after release frameStart=1, frameCount=0.
- 800x600 params (800/40/128/88, 600/1/4/23), HSYNC_POL=VSYNC_POL=0 -> line 1056, frame 628 lines, hsync low 128 cycles, DE 480000 per frame.
- VGA_TEST_PATTERN_EN, patternSel=0 -> x=0 FFF, x=80 FF0, x=639 000; switch to 2 mid-frame -> bars until next frameStart, then FFF.
